regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32I datapath. It replaces the fixed 2-read/1-write file with a configurable number of read ports, two prioritised write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. After reset, a sequential clear sweep zeroes the array one entry per cycle. The datapath stalls until `ready` asserts.

---
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port RV32I integer register file with two prioritised write ports,
// optional write-to-read bypass, a per-register busy scoreboard and a post-reset clear sweep.
module regfile_mp #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int AW           = 5,
    parameter int NRD          = 2,
    parameter int WRITE_BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                set_busy,
    input  logic [AW-1:0]       set_addr,
    output logic [NREGS-1:0]    busy
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_ptr;
    logic [XLEN-1:0]   r_mem [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;
    logic              w_run;
    logic              w_we0;
    logic              w_we1;
    logic [AW-1:0]     w_ra;

    assign w_run = (r_state == S_RUN);
    // Writes to x0 are dropped here so the array entry 0 is never written.
    assign w_we0 = w_run && we0 && (wa0 != '0);
    assign w_we1 = w_run && we1 && (wa1 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR)
                r_ptr <= r_ptr + AW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_ptr == AW'(NREGS - 1))
            w_state_nxt = S_RUN;
    end

    assign ready = w_run;

    // Array is data only: reset leaves it alone, the sweep zeroes it afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_mem[r_ptr] <= '0;
            end else begin
                if (w_we0)
                    r_mem[wa0] <= wd0;
                if (w_we1)
                    r_mem[wa1] <= wd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        w_ra    = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra = rd_addr[k*AW +: AW];
            if (w_run && w_ra != '0) begin
                if (WRITE_BYPASS != 0 && w_we1 && wa1 == w_ra)
                    rd_data[k*XLEN +: XLEN] = wd1;
                else if (WRITE_BYPASS != 0 && w_we0 && wa0 == w_ra)
                    rd_data[k*XLEN +: XLEN] = wd0;
                else
                    rd_data[k*XLEN +: XLEN] = r_mem[w_ra];
            end
        end
    end

    // A new producer issued in the same cycle as the old one's writeback keeps the register busy.
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_busy_nxt[i] = (set_busy && set_addr == AW'(i)) ||
                            (r_busy[i] && !((w_we0 && wa0 == AW'(i)) ||
                                            (w_we1 && wa1 == AW'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else if (w_run)
            r_busy <= w_busy_nxt;
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic                we0, we1, set_busy;
    logic [AW-1:0]       wa0, wa1, set_addr;
    logic [XLEN-1:0]     wd0, wd1;
    logic                ready_b, ready_n;
    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NREGS-1:0]    busy_b, busy_n;

    int n_tests = 0;
    int n_fail  = 0;
    int n_edges;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .WRITE_BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .set_busy(set_busy), .set_addr(set_addr), .busy(busy_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .WRITE_BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ready(ready_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .set_busy(set_busy), .set_addr(set_addr), .busy(busy_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        we0 = 1'b0; we1 = 1'b0; set_busy = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; set_addr = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd(5'd0, 5'd0);

        // Reset sweep
        tick(); tick();
        chk("reset_ready", {62'd0, ready_b, ready_n}, 64'd0);
        chk("reset_busy", {busy_b, busy_n}, 64'd0);
        rst = 1'b0;
        n_edges = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_edges++;
            if (ready_b) break;
            if (n_edges == 20) begin
                we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hCAFE_F00D;
                we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h1234_5678;
                set_busy = 1'b1; set_addr = 5'd3;
                rd(5'd3, 5'd2);
                #1;
                chk("sweep_rd_bypass", rd_data_b, 64'd0);
                chk("sweep_rd_nobypass", rd_data_n, 64'd0);
            end
            if (n_edges == 21) idle();
        end
        chk("sweep_edges", 64'(n_edges), 64'd31);
        chk("sweep_ready_both", {62'd0, ready_b, ready_n}, 64'd3);
        rd(5'd3, 5'd2);
        #1;
        chk("post_sweep_ignored_writes", rd_data_b, 64'd0);
        chk("post_sweep_busy", {busy_b, busy_n}, 64'd0);
        rd(5'd31, 5'd17);
        #1;
        chk("post_sweep_rd_31_17", rd_data_n, 64'd0);

        // Reset mid-sweep
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("midsweep_not_ready", {63'd0, ready_b}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_edges = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_edges++;
            if (ready_b) break;
        end
        chk("restart_sweep_edges", 64'(n_edges), 64'd31);

        // Dual write, same address: port 1 wins
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1111_1111;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h2222_2222;
        tick();
        idle();
        rd(5'd5, 5'd5);
        #1;
        chk("prio_x5_nb", rd_data_n, {32'h2222_2222, 32'h2222_2222});
        chk("prio_x5_b", rd_data_b, {32'h2222_2222, 32'h2222_2222});

        // Dual write, different addresses
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h3333_3333;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h4444_4444;
        tick();
        idle();
        rd(5'd4, 5'd3);
        #1;
        chk("dual_x3_x4", rd_data_n, {32'h4444_4444, 32'h3333_3333});

        // Bypass vs stored value
        rd(5'd7, 5'd7);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEAD_BEEF;
        #1;
        chk("bypass_same_cycle", rd_data_b, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        chk("nobypass_same_cycle", rd_data_n, 64'd0);
        tick();
        idle();
        #1;
        chk("nobypass_next_cycle", rd_data_n, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

        // Bypass priority: port 1 data forwarded over port 0
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5A5_A5A5;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5A5A_5A5A;
        rd(5'd3, 5'd7);
        #1;
        chk("bypass_prio", rd_data_b, {32'h3333_3333, 32'h5A5A_5A5A});
        chk("nobypass_prio_old", rd_data_n, {32'h3333_3333, 32'hDEAD_BEEF});
        tick();
        idle();
        #1;
        chk("nobypass_prio_new", rd_data_n, {32'h3333_3333, 32'h5A5A_5A5A});

        // x0 stays zero and never busy
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        set_busy = 1'b1; set_addr = 5'd0;
        rd(5'd0, 5'd0);
        #1;
        chk("x0_bypass_zero", rd_data_b, 64'd0);
        tick();
        idle();
        #1;
        chk("x0_stored_zero", {rd_data_b | rd_data_n}, 64'd0);
        chk("x0_not_busy", {busy_b, busy_n}, 64'd0);

        // Scoreboard
        set_busy = 1'b1; set_addr = 5'd9;
        tick();
        idle();
        chk("sb_set_x9", {busy_b, busy_n}, {32'h0000_0200, 32'h0000_0200});
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0009;
        set_busy = 1'b1; set_addr = 5'd9;
        tick();
        idle();
        chk("sb_set_wins", {32'd0, busy_b}, 64'h0000_0200);
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0099;
        tick();
        idle();
        chk("sb_clear_x9", {busy_b, busy_n}, 64'd0);
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h0000_000C;
        tick();
        idle();
        rd(5'd12, 5'd9);
        #1;
        chk("sb_write_nonbusy", {32'd0, busy_n}, 64'd0);
        chk("sb_data_x9_x12", rd_data_b, {32'h0000_000C, 32'h0000_0099});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
